// File: rtl/sha256_expand_sched.sv
// Sequencer for the 4-way interleaved SHA-256 schedule expander: buffers up to four blocks,
// feeds 64 slot-ordered words, then tags the expander output. Optional abort: SHA256_EXPAND_SCHED_ABORT_EN.
module sha256_expand_sched #(
   parameter logic [31:0] PAD_WORD = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [3:0]  lane_mask_i,
   output logic        busy_o,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_data_i,
   output logic        exp_send_o,
   output logic [31:0] exp_data_o,
   input  logic [31:0] exp_data_i,
   output logic        w_valid_o,
   output logic [31:0] w_data_o,
   output logic [5:0]  w_idx_o,
   output logic [1:0]  w_lane_o,
`ifdef SHA256_EXPAND_SCHED_ABORT_EN
   input  logic        abort_i,
`endif
   output logic        done_o
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t      state;
   logic [3:0]  mask;
   logic [5:0]  ptr;
   logic [8:0]  cnt;
   logic [31:0] buf_mem [64];
   logic [31:0] fwd_q;

   logic        slot_en;
   logic        xfer;
   logic        step;
   logic        abort;
   logic        send_phase;
   logic        out_phase;
   logic [7:0]  slot;
   logic [31:0] send_word;

   function automatic logic [1:0] first_lane(input logic [3:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

`ifdef SHA256_EXPAND_SCHED_ABORT_EN
   assign abort = abort_i && (state != IDLE);
`else
   assign abort = 1'b0;
`endif

   assign slot_en = mask[ptr[1:0]];
   assign xfer    = in_valid_i && in_ready_o;
   // The load pointer visits every slot; disabled ones take one cycle each to pad.
   assign step    = (state == LOAD) && (!slot_en || xfer);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         mask  <= 4'd0;
         ptr   <= 6'd0;
         cnt   <= 9'd0;
      end else if (abort) begin
         state <= IDLE;
         cnt   <= 9'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i && (lane_mask_i != 4'd0)) begin
                  mask  <= lane_mask_i;
                  ptr   <= {4'd0, first_lane(lane_mask_i)};
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (step) begin
                  if (ptr == 6'd63) begin
                     state <= RUN;
                     cnt   <= 9'd0;
                  end else begin
                     ptr <= ptr + 6'd1;
                  end
               end
            end
            RUN: begin
               if (cnt == 9'd256) begin
                  state <= IDLE;
                  cnt   <= 9'd0;
               end else begin
                  cnt <= cnt + 9'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Leading slots skipped at start are never written, so the read side substitutes
   // PAD_WORD for every disabled lane rather than trusting buffer contents.
   assign send_word  = mask[cnt[1:0]] ? buf_mem[cnt[5:0]] : PAD_WORD;
   assign send_phase = (state == RUN) && (cnt[8:6] == 3'd0);
   assign out_phase  = (state == RUN) && (cnt != 9'd0);
   assign slot       = cnt[7:0] - 8'd1;

   // stage p0 -> p1: buffer write on load, forward copy of each sent word
   always_ff @(posedge clk_i) begin
      if (step)
         buf_mem[ptr] <= slot_en ? in_data_i : PAD_WORD;
      if (send_phase)
         fwd_q <= send_word;
   end

   assign busy_o     = (state != IDLE);
   assign in_ready_o = (state == LOAD) && slot_en;
   assign exp_send_o = send_phase;
   assign exp_data_o = send_phase ? send_word : 32'd0;
   assign w_valid_o  = out_phase && mask[slot[1:0]];
   assign w_data_o   = !out_phase ? 32'd0 : ((slot[7:6] == 2'b00) ? fwd_q : exp_data_i);
   assign w_idx_o    = out_phase ? slot[7:2] : 6'd0;
   assign w_lane_o   = out_phase ? slot[1:0] : 2'd0;
   assign done_o     = (state == RUN) && (cnt == 9'd256);

endmodule

// File: tb/tb_sha256_expand_sched.sv
// Bench for sha256_expand_sched: a behavioural expander drives exp_data_i, and the tagged
// schedule stream is compared with SHA-256 schedules computed directly from the loaded blocks.
module tb_sha256_expand_sched;

   localparam logic [31:0] PAD = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  lane_mask;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        exp_send;
   logic [31:0] exp_out;
   logic [31:0] exp_in;
   logic        w_valid;
   logic [31:0] w_data;
   logic [5:0]  w_idx;
   logic [1:0]  w_lane;
   logic        done;
`ifdef SHA256_EXPAND_SCHED_ABORT_EN
   logic        abort;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] msg  [4][16];
   logic [31:0] gold [4][64];
   logic [31:0] xslots [256];
   int          xt;
   logic        prev_send;

   always #5 clk = ~clk;

   sha256_expand_sched #(.PAD_WORD(PAD)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .lane_mask_i(lane_mask),
      .busy_o(busy), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .exp_send_o(exp_send), .exp_data_o(exp_out), .exp_data_i(exp_in),
      .w_valid_o(w_valid), .w_data_o(w_data), .w_idx_o(w_idx), .w_lane_o(w_lane),
`ifdef SHA256_EXPAND_SCHED_ABORT_EN
      .abort_i(abort),
`endif
      .done_o(done)
   );

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] sg0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] sg1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   // Expander: slots sent in order, then slot s computed from s-8, s-28, s-60, s-64
   // and presented during the cycle after it is formed.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xt        <= 0;
         prev_send <= 1'b0;
      end else begin
         prev_send <= exp_send;
         if (exp_send) begin
            if (!prev_send || xt >= 64) begin
               xslots[0] <= exp_out;
               xt        <= 1;
            end else begin
               xslots[xt] <= exp_out;
               xt         <= xt + 1;
            end
         end else if (xt >= 64 && xt < 256) begin
            xslots[xt] <= sg1(xslots[xt-8]) + xslots[xt-28] + sg0(xslots[xt-60]) + xslots[xt-64];
            xt         <= xt + 1;
         end
      end
   end
   assign exp_in = (xt >= 65 && xt <= 256) ? xslots[(xt >= 1) ? xt - 1 : 0] : 32'hDEAD_BEEF;

   function automatic void compute_gold();
      for (int l = 0; l < 4; l++) begin
         for (int t = 0; t < 16; t++) gold[l][t] = msg[l][t];
         for (int t = 16; t < 64; t++)
            gold[l][t] = sg1(gold[l][t-2]) + gold[l][t-7] + sg0(gold[l][t-15]) + gold[l][t-16];
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fill(input bit abc);
      for (int l = 0; l < 4; l++)
         for (int t = 0; t < 16; t++) msg[l][t] = $urandom;
      if (abc) begin
         for (int t = 0; t < 16; t++) msg[0][t] = 32'd0;
         msg[0][0]  = 32'h6162_6380;
         msg[0][15] = 32'h0000_0018;
      end
      compute_gold();
   endtask

   task automatic quiet_check(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, in_ready, 0);
      chk({tag, "_send"}, exp_send, 0);
      chk({tag, "_valid"}, w_valid, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_wdata"}, w_data, 0);
   endtask

   // cut_at >= 0 interrupts RUN at that count: by reset (cut_abort=0) or abort (cut_abort=1).
   task automatic run_session(input logic [3:0] m, input bit toggle, input bit abc,
                              input int cut_at, input bit cut_abort);
      int slots[$];
      int k, cyc, extra, nv, s, bad;
      logic v, r, ev;
      logic [31:0] ed;
      for (int i = 0; i < 64; i++) if (m[i % 4]) slots.push_back(i);

      start = 1'b1; lane_mask = m;
      @(negedge clk);
      start = 1'b0; lane_mask = 4'($urandom);
      chk("load_busy", busy, 1);

      k = 0; cyc = 0; bad = 0;
      while (k < slots.size() && cyc < 3000) begin
         v = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid = v;
         in_data  = msg[slots[k] % 4][slots[k] / 4];
         r = in_ready;
         if (exp_send) bad++;
         @(negedge clk);
         cyc++;
         if (v && r) k++;
      end
      chk("load_count", k, slots.size());
      chk("send_early", bad, 0);

      in_valid = 1'b1; in_data = $urandom; extra = 0; cyc = 0;
      while (exp_send !== 1'b1 && cyc < 200) begin
         if (in_ready) extra++;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk("extra_words", extra, 0);
      chk("run_start", exp_send, 1);
      if (exp_send !== 1'b1) return;

      nv = 0;
      for (int c = 0; c <= 256; c++) begin
         if (c == cut_at && !cut_abort) begin
            rst_n = 1'b0;
            #1;
            quiet_check("mid_reset");
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         chk("busy", busy, 1);
         chk("exp_send", exp_send, (c < 64) ? 1 : 0);
         ed = (c < 64) ? (m[c % 4] ? msg[c % 4][c / 4] : PAD) : 32'd0;
         chk("exp_data", exp_out, ed);
         s  = c - 1;
         ev = (c >= 1) ? m[s % 4] : 1'b0;
         chk("w_valid", w_valid, ev);
         if (ev) begin
            nv++;
            chk("w_data", w_data, gold[s % 4][s / 4]);
            chk("w_idx", w_idx, s / 4);
            chk("w_lane", w_lane, s % 4);
            if (abc && s == 64) chk("abc_w16", w_data, 32'h6162_6380);
            if (abc && s == 68) chk("abc_w17", w_data, 32'h000F_0000);
         end
         chk("done", done, (c == 256) ? 1 : 0);
`ifdef SHA256_EXPAND_SCHED_ABORT_EN
         if (c == cut_at && cut_abort) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_valid", w_valid, 0);
            chk("abort_send", exp_send, 0);
            bad = 0;
            repeat (300) begin
               @(negedge clk);
               if (w_valid || done || exp_send || busy) bad++;
            end
            chk("abort_quiet", bad, 0);
            return;
         end
`endif
         @(negedge clk);
      end
      chk("valid_count", nv, 64 * $countones(m));
      chk("end_busy", busy, 0);
      chk("end_done", done, 0);
   endtask

   initial begin
      logic [3:0] rm;
      rst_n = 1'b0; start = 1'b1; lane_mask = 4'hF; in_valid = 1'b0; in_data = 32'd0;
`ifdef SHA256_EXPAND_SCHED_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      quiet_check("reset");
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_reset_busy", busy, 0);

      start = 1'b1; lane_mask = 4'h0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("mask0_ignored", busy, 0);

      fill(1'b1);
      run_session(4'hF, 1'b0, 1'b1, -1, 1'b0);

      fill(1'b0);
      run_session(4'b0101, 1'b0, 1'b0, -1, 1'b0);

      fill(1'b0);
      rm = 4'($urandom_range(1, 15));
      run_session(rm, 1'b1, 1'b0, -1, 1'b0);

      fill(1'b0);
      run_session(4'hF, 1'b1, 1'b0, 100, 1'b0);
      fill(1'b0);
      run_session(4'hF, 1'b0, 1'b0, -1, 1'b0);

`ifdef SHA256_EXPAND_SCHED_ABORT_EN
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_noop", busy, 0);
      fill(1'b0);
      run_session(4'hF, 1'b0, 1'b0, 30, 1'b1);
      start = 1'b1; lane_mask = 4'h0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort_mask0_idle", busy, 0);
      fill(1'b0);
      run_session(4'b1010, 1'b1, 1'b0, -1, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sha256_expand_sched.md
Name: sha256_expand_sched

Overview:
- Sequencer for the 4-way interleaved SHA-256 message-schedule expander.
- Buffers up to four 512-bit message blocks, one per lane, as 64 slot-ordered 32-bit words.
- Drives the expander's send/data inputs for exactly 64 cycles, then lets it free-run.
- Re-labels the expander output as a tagged W[0..63] stream (lane, index, valid) for the compression rounds.

Parameters:
PAD_WORD, 32'h0000_0000, value stored in the slots of disabled lanes.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous, active-low
start_i  input  1  begin a session; sampled only in IDLE
lane_mask_i  input  4  enabled lanes; captured with start_i
busy_o  output  1  high in LOAD and RUN
in_valid_i  input  1  load word valid
in_ready_o  output  1  load word ready; high only in LOAD
in_data_i  input  32  load word
exp_send_o  output  1  to expander send_i
exp_data_o  output  32  to expander data_i
exp_data_i  input  32  from expander data_o
w_valid_o  output  1  schedule word valid
w_data_o  output  32  schedule word W[idx] of lane
w_idx_o  output  6  word index 0..63
w_lane_o  output  2  lane 0..3
done_o  output  1  one-cycle pulse at end of session

Behaviour:
- Slot numbering: slot s = 4*k + L, where k = word index and L = lane. Buffer: 64 x 32-bit, indexed by slot.
- Reset (async, rst_ni low): FSM goes to IDLE, counters 0, mask 0. All outputs 0. Takes effect immediately, including mid-LOAD or mid-RUN. Buffer contents need no reset.
- IDLE:
  - start_i=1 with lane_mask_i != 0: capture mask, load pointer p=0 skipped forward to the first enabled-lane slot, go to LOAD.
  - start_i with mask 0: ignored.
- LOAD:
  - in_ready_o=1. A word transfers on in_valid_i && in_ready_o and is written to buf[p].
  - p then advances to the next slot whose lane bit is set.
  - Disabled-lane slots are written PAD_WORD, one per cycle, while the pointer skips them.
  - Exactly 16 x popcount(mask) words are accepted, in ascending slot order.
  - After the last enabled slot is accepted, any remaining skipped slots are written PAD_WORD. Next cycle: RUN with cnt=0.
  - in_valid_i low: hold, no timeout.
- RUN (cnt counts 0..256):
  - cnt 0..63: exp_send_o=1, exp_data_o=buf[cnt]; register fwd_q <= buf[cnt].
  - cnt >= 64: exp_send_o=0, exp_data_o=0.
  - Expander timing is fixed: slot s in 64..255 appears on exp_data_i during cnt == s+1.
  - Output stream during cnt 1..256, with s = cnt-1:
    - w_data_o = fwd_q if s<64, else exp_data_i.
    - w_idx_o = s>>2, w_lane_o = s[1:0].
    - w_valid_o = mask[s[1:0]].
  - Outside cnt 1..256, or outside RUN: w_valid_o=0, w_data_o/idx/lane=0.
  - No backpressure: the consumer accepts every valid cycle.
  - cnt==256: done_o=1 (one cycle); next cycle IDLE.
  - start_i is ignored in LOAD and RUN. Earliest next start is the first IDLE cycle.
- Back-to-back sessions need no expander flush: 64 send cycles fully overwrite its pipeline.
- cnt width is 9 bits; no wrap within a session.

Optional Feature:
- Macro: SHA256_EXPAND_SCHED_ABORT_EN.
- Defined: adds input abort_i (1 bit).
  - abort_i=1 in LOAD or RUN: next cycle IDLE.
  - exp_send_o and w_valid_o are 0 from that next cycle.
  - No done_o; no partial words emitted afterwards.
  - abort_i in IDLE has no effect.
- Undefined: no abort_i port; sessions always complete.

Test Plan:
- Reset: hold rst_ni=0 -> busy_o, in_ready_o, exp_send_o, w_valid_o, done_o all 0; start_i while in reset ignored.
- Mask 4'hF, lane 0 loaded with "abc" block (W0=0x61626380, W1..W14=0, W15=0x18), lanes 1..3 random:
  - exactly 64 words accepted; exp_send_o high 64 cycles.
  - lane 0: W16=0x61626380, W17=0x000F0000, plus full golden W[0..63] match.
  - 256 valids; done_o at cnt 256.
- Mask 4'b0101: exactly 32 words accepted -> 128 valids, lanes 0 and 2 only. Lane 1/3 slots fed PAD_WORD on exp_data_o. Lane 0/2 schedules match golden.
- in_valid_i toggling randomly during LOAD -> no skipped or duplicated words; exp_send_o stays 0 until LOAD completes; schedule matches golden.
- rst_ni pulsed low at RUN cnt=100 -> all outputs 0 immediately; following fresh session with new data matches golden (no stale words).
- With SHA256_EXPAND_SCHED_ABORT_EN: abort_i at RUN cnt=30 -> IDLE next cycle, no further w_valid_o, no done_o; start_i with mask 0 in IDLE -> stays IDLE.
